// File: rtl/um_ctrl_responder.sv
// Control-path responder: decodes single-flit register write/read commands,
// holds the um configuration registers and returns read completions.
module um_ctrl_responder #(
  parameter logic [27:0] MODULE_ID = 28'h0008007,
  parameter logic [7:0]  BLOCK_SEL = 8'h70,
  parameter logic [7:0]  PROTO_RST = 8'h00,
  parameter logic [31:0] NRTT_RST  = 32'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] dma2um_data,
  input  logic         dma2um_data_wr,
  output logic         um2dma_ready,
  output logic [133:0] um2dma_data,
  output logic         um2dma_data_wr,
  input  logic         dma2um_ready,
  input  logic [63:0]  scm_bit_num_cnt,
  input  logic [63:0]  scm_pkt_num_cnt,
  input  logic [63:0]  scm_time_cnt,
  output logic [7:0]   protocol_type,
  output logic         statistic_reset,
  output logic [31:0]  n_rtt,
  output logic [15:0]  cfg_err_cnt
);

  // Handshake: a command is accepted on a rising edge where dma2um_data_wr
  // and um2dma_ready are both 1; a completion is taken on a rising edge where
  // um2dma_data_wr and dma2um_ready are both 1.
  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;
  logic   started_q;

  logic [1:0]  cmd_type;
  logic [3:0]  opcode;
  logic [27:0] cmd_id;
  logic [7:0]  cmd_blk;
  logic [23:0] cmd_idx;
  logic [63:0] cmd_data;

  assign cmd_type = dma2um_data[133:132];
  assign opcode   = dma2um_data[127:124];
  assign cmd_id   = dma2um_data[123:96];
  assign cmd_blk  = dma2um_data[95:88];
  assign cmd_idx  = dma2um_data[87:64];
  assign cmd_data = dma2um_data[63:0];

  logic unused_bits;
  assign unused_bits = ^{dma2um_data[131:128], cmd_data[63:32]};

  logic accept, hdr_ok, blk_ok, is_wr, is_rd, wr_hit, rd_map, err_ev;
  logic [63:0] rd_value;

  // Ready is held low until the first clock after reset release.
  assign um2dma_ready = started_q && (state_q == IDLE);
  assign accept = dma2um_data_wr && um2dma_ready;
  assign hdr_ok = (cmd_type == 2'b01) && (cmd_id == MODULE_ID);
  assign blk_ok = (cmd_blk == BLOCK_SEL);
  assign is_wr  = accept && hdr_ok && (opcode == 4'hA);
  assign is_rd  = accept && hdr_ok && (opcode == 4'hB);
  assign wr_hit = is_wr && blk_ok && (cmd_idx <= 24'd2);
  assign rd_map = blk_ok && (cmd_idx <= 24'd5);
  // Every accepted flit that is neither a writable hit nor a mapped read is an error.
  assign err_ev = accept && !(wr_hit || (is_rd && rd_map));

  always_comb begin
    rd_value = '0;
    if (blk_ok) begin
      case (cmd_idx)
        24'd0:   rd_value = {56'd0, protocol_type};
        24'd2:   rd_value = {32'd0, n_rtt};
        24'd3:   rd_value = scm_bit_num_cnt;
        24'd4:   rd_value = scm_pkt_num_cnt;
        24'd5:   rd_value = scm_time_cnt;
        default: rd_value = '0;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    um2dma_data_wr = 1'b0;
    case (state_q)
      IDLE: if (is_rd) state_d = RESP;
      RESP: begin
        if (dma2um_ready) begin
          um2dma_data_wr = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_type   <= PROTO_RST;
      n_rtt           <= NRTT_RST;
      statistic_reset <= 1'b0;
      um2dma_data     <= '0;
    end else begin
      statistic_reset <= wr_hit && (cmd_idx == 24'd1) && cmd_data[0];
      if (wr_hit && (cmd_idx == 24'd0)) protocol_type <= cmd_data[7:0];
      if (wr_hit && (cmd_idx == 24'd2)) n_rtt <= cmd_data[31:0];
      // Completion is built at accept so RO counters are frozen at that edge.
      if (is_rd) um2dma_data <= {2'b01, 4'b0000, 4'hC, cmd_id, cmd_blk, cmd_idx, rd_value};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_cnt <= '0;
    end else if (err_ev && (cfg_err_cnt != 16'hFFFF)) begin
      cfg_err_cnt <= cfg_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_um_ctrl_responder.sv
// Directed bench for um_ctrl_responder: completions are checked by a
// scoreboard monitor, configuration outputs by direct comparisons.
module tb_um_ctrl_responder;

  logic         clk;
  logic         rst_n;
  logic [133:0] dma2um_data;
  logic         dma2um_data_wr;
  logic         um2dma_ready;
  logic [133:0] um2dma_data;
  logic         um2dma_data_wr;
  logic         dma2um_ready;
  logic [63:0]  scm_bit_num_cnt;
  logic [63:0]  scm_pkt_num_cnt;
  logic [63:0]  scm_time_cnt;
  logic [7:0]   protocol_type;
  logic         statistic_reset;
  logic [31:0]  n_rtt;
  logic [15:0]  cfg_err_cnt;

  um_ctrl_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma2um_data     (dma2um_data),
    .dma2um_data_wr  (dma2um_data_wr),
    .um2dma_ready    (um2dma_ready),
    .um2dma_data     (um2dma_data),
    .um2dma_data_wr  (um2dma_data_wr),
    .dma2um_ready    (dma2um_ready),
    .scm_bit_num_cnt (scm_bit_num_cnt),
    .scm_pkt_num_cnt (scm_pkt_num_cnt),
    .scm_time_cnt    (scm_time_cnt),
    .protocol_type   (protocol_type),
    .statistic_reset (statistic_reset),
    .n_rtt           (n_rtt),
    .cfg_err_cnt     (cfg_err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [133:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && um2dma_data_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", um2dma_data, '1);
      end else begin
        check("completion", um2dma_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [133:0] mk(input logic [127:0] body);
    return {2'b01, 4'b0000, body};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [133:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!um2dma_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!um2dma_ready) check("send_ready_timeout", {133'd0, um2dma_ready}, 134'd1);
    dma2um_data    = f;
    dma2um_data_wr = 1'b1;
    @(posedge clk);
    #1 dma2um_data_wr = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    dma2um_data     = '0;
    dma2um_data_wr  = 1'b0;
    dma2um_ready    = 1'b1;
    scm_bit_num_cnt = 64'hAAAA_0000_0000_0001;
    scm_pkt_num_cnt = 64'h0;
    scm_time_cnt    = 64'h55;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_proto", protocol_type, 8'h00);
    check("rst_nrtt", n_rtt, 32'd0);
    check("rst_err", cfg_err_cnt, 16'd0);
    check("rst_stat", statistic_reset, 1'b0);
    check("rst_ready", um2dma_ready, 1'b0);
    check("rst_data", um2dma_data, 134'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", um2dma_ready, 1'b1);

    // Write protocol_type
    send(mk(128'hA0008007_70000000_00000000_00000082));
    @(negedge clk);
    check("wr_proto", protocol_type, 8'h82);

    // statistic_reset pulse, then no pulse
    send(mk(128'hA0008007_70000001_00000000_00000001));
    @(negedge clk);
    check("stat_pulse_hi", statistic_reset, 1'b1);
    @(negedge clk);
    check("stat_pulse_lo", statistic_reset, 1'b0);
    send(mk(128'hA0008007_70000001_00000000_00000000));
    @(negedge clk);
    check("stat_nopulse_0", statistic_reset, 1'b0);
    @(negedge clk);
    check("stat_nopulse_1", statistic_reset, 1'b0);

    // n_rtt write then read back, minimum latency
    send(mk(128'hA0008007_70000002_00000000_00000030));
    @(negedge clk);
    check("wr_nrtt", n_rtt, 32'h30);
    exp_q.push_back(mk(128'hC0008007_70000002_00000000_00000030));
    send(mk(128'hB0008007_70000002_00000000_00000000));
    @(negedge clk);
    check("rd_latency_strobe", um2dma_data_wr, 1'b1);
    check("rd_ready_low", um2dma_ready, 1'b0);
    wait_drained();

    // Back-to-back read of a RO counter with back-pressure
    dma2um_ready    = 1'b0;
    scm_pkt_num_cnt = 64'h1234;
    exp_q.push_back(mk(128'hC0008007_70000004_00000000_00001234));
    send(mk(128'hB0008007_70000004_00000000_00000000));
    scm_pkt_num_cnt = 64'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_strobe", um2dma_data_wr, 1'b0);
      check("stall_data_stable", um2dma_data, mk(128'hC0008007_70000004_00000000_00001234));
      if (i == 1) begin
        dma2um_data    = mk(128'hA0008007_70000000_00000000_00000077);
        dma2um_data_wr = 1'b1;
      end
      if (i == 2) dma2um_data_wr = 1'b0;
    end
    @(posedge clk);
    #1 dma2um_ready = 1'b1;
    wait_drained();
    check("ignored_strobe_proto", protocol_type, 8'h82);
    check("ignored_strobe_err", cfg_err_cnt, 16'd0);

    // Dropped commands
    send(mk(128'hA0008008_70000000_00000000_00000011));
    send(mk(128'h50008007_70000000_00000000_00000011));
    send(mk(128'hA0008007_70000003_00000000_00000011));
    @(negedge clk);
    check("drop_err3", cfg_err_cnt, 16'd3);
    check("drop_proto", protocol_type, 8'h82);
    check("drop_nrtt", n_rtt, 32'h30);
    send({2'b10, 4'b0000, 128'hA0008007_70000000_00000000_00000011});
    @(negedge clk);
    check("bad_type_err", cfg_err_cnt, 16'd4);
    check("bad_type_proto", protocol_type, 8'h82);
    exp_q.push_back(mk(128'hC0008007_70000007_00000000_00000000));
    send(mk(128'hB0008007_70000007_00000000_00000000));
    wait_drained();
    check("unmapped_rd_err", cfg_err_cnt, 16'd5);
    exp_q.push_back(mk(128'hC0008007_70000001_00000000_00000000));
    send(mk(128'hB0008007_70000001_00000000_00000000));
    wait_drained();
    check("wo_rd_err", cfg_err_cnt, 16'd5);

    // Reset while a completion is pending
    dma2um_ready = 1'b0;
    send(mk(128'hB0008007_70000000_00000000_00000000));
    #1 rst_n = 1'b0;
    #1;
    check("rst_resp_strobe", um2dma_data_wr, 1'b0);
    check("rst_resp_ready", um2dma_ready, 1'b0);
    check("rst_resp_data", um2dma_data, 134'd0);
    check("rst_resp_proto", protocol_type, 8'h00);
    check("rst_resp_nrtt", n_rtt, 32'd0);
    check("rst_resp_err", cfg_err_cnt, 16'd0);
    dma2um_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_ready", um2dma_ready, 1'b1);
    exp_q.push_back(mk(128'hC0008007_70000002_00000000_00000000));
    send(mk(128'hB0008007_70000002_00000000_00000000));
    wait_drained();
    check("post_rst_err", cfg_err_cnt, 16'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/um_ctrl_responder.md
Name: um_ctrl_responder

Overview:
- Control-path responder inside um: terminates software register-access commands arriving on the dma2um channel and returns read completions on the um2dma channel.
- Decodes single-flit 134-bit write/read commands, holds the um configuration registers (protocol_type, statistic_reset, n_RTT) and exposes the read-only statistics counters (scm_*_cnt) to software.

Parameters:
- MODULE_ID, 28'h0008007, command target ID; a flit whose ID field differs is dropped.
- BLOCK_SEL, 8'h70, address block select; other block selects are unmapped.
- PROTO_RST, 8'h00, reset value of protocol_type.
- NRTT_RST, 32'd0, reset value of n_rtt.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dma2um_data  in  134  command flit: [133:132] type, [131:128] ignored, [127:0] body
- dma2um_data_wr  in  1  flit strobe; valid only while um2dma_ready=1
- um2dma_ready  out  1  block can accept a command
- um2dma_data  out  134  completion flit
- um2dma_data_wr  out  1  one-cycle completion strobe
- dma2um_ready  in  1  DMA side can accept a completion this cycle
- scm_bit_num_cnt  in  64  read-only statistic
- scm_pkt_num_cnt  in  64  read-only statistic
- scm_time_cnt  in  64  read-only statistic
- protocol_type  out  8  config register
- statistic_reset  out  1  one-cycle clear pulse to the statistics logic
- n_rtt  out  32  config register
- cfg_err_cnt  out  16  count of dropped or erroneous commands, saturating

Behaviour:
- Flit body layout:
  - [127:124] opcode: A=write, B=read, C=completion.
  - [123:96] ID.
  - [95:88] block select.
  - [87:64] register index.
  - [63:0] data.
- A command is valid only when [133:132]=2'b01; any other type is dropped and cfg_err_cnt increments.
- Accept: a flit is accepted on the edge where dma2um_data_wr=1 and um2dma_ready=1. A strobe while ready=0 is ignored, with no count.
- Register map:
  - idx 0: protocol_type, RW, data[7:0].
  - idx 1: statistic_reset, WO; read returns 0.
  - idx 2: n_rtt, RW, data[31:0].
  - idx 3: scm_bit_num_cnt, RO.
  - idx 4: scm_pkt_num_cnt, RO.
  - idx 5: scm_time_cnt, RO.
  - RW register reads are zero-extended to 64 bits.
- Write (opcode A, ID match, block match):
  - The register updates on the accept edge, so the new value is visible on the next cycle.
  - statistic_reset pulses high for exactly one cycle after the accept edge when data[0]=1; data[0]=0 gives no pulse.
  - Writes never produce a completion.
  - A write to a RO register or to an unmapped index or block changes nothing and increments cfg_err_cnt.
- Read (opcode B, ID match):
  - The selected value is sampled on the accept edge; the RO inputs are captured at that edge.
  - The FSM moves IDLE→RESP.
  - Completion flit: {2'b01, 4'b0000, 4'hC, ID, blk, idx, value}.
  - Unmapped block or index returns value 0 and increments cfg_err_cnt.
- ID mismatch or an opcode other than A/B: the flit is dropped, cfg_err_cnt increments, and there is no register effect.
- FSM:
  - IDLE: um2dma_ready=1.
  - RESP: um2dma_ready=0. um2dma_data_wr=1 in the first RESP cycle with dma2um_ready=1, then the FSM returns to IDLE, so the next command can be accepted on the following cycle.
  - Minimum read latency: completion strobe one cycle after the accept edge.
  - In RESP, um2dma_data holds stable until the strobe.
- Throughput:
  - Writes: back-to-back, one per cycle.
  - Reads: one per 2 cycles maximum.
- cfg_err_cnt saturates at 16'hFFFF.
- Reset (asynchronous, any time):
  - protocol_type=PROTO_RST, n_rtt=NRTT_RST.
  - statistic_reset=0, cfg_err_cnt=0.
  - um2dma_data=0, um2dma_data_wr=0.
  - um2dma_ready=0 while rst_n=0, and 1 from the first clock after release.
  - FSM→IDLE; a pending completion is discarded and never emitted.

Test Plan:
- Write {01,0000,A0008007_70000000_00000000_00000082} with dma2um_ready=1 → protocol_type=8'h82 next cycle; no um2dma_data_wr.
- Write body A0008007_70000001_00000000_00000001 → statistic_reset high exactly 1 cycle; repeat with data 0 → no pulse.
- Write body A0008007_70000002_00000000_00000030, then read idx 2 (B0008007_70000002_…) → completion body C0008007_70000002_00000000_00000030, strobe 1 cycle after accept, um2dma_ready low for that cycle.
- Read idx 4 with scm_pkt_num_cnt=64'h1234 and dma2um_ready held 0 for 5 cycles → no strobe and stable um2dma_data for 5 cycles; strobe on the cycle ready rises; value 64'h1234 even if the input changes meanwhile.
- ID 28'h0008008, opcode 4'h5, and write to idx 3 → all dropped, registers unchanged, cfg_err_cnt=3.
- Issue a read, assert rst_n=0 while in RESP → no strobe ever, all outputs at reset values; after release the next read completes normally.
